// File: rtl/branch_cond_unit.sv
// NZP condition-code register plus branch-enable evaluation, with optional
// same-cycle CC bypass and saturating branch/taken statistics counters.
module branch_cond_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int BYPASS = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_CC,
    input  logic [DATA_W-1:0] Bus,
    input  logic              LD_BEN,
    input  logic [2:0]        IR_cond,
    input  logic              Clr_Stats,
    output logic              N,
    output logic              Z,
    output logic              P,
    output logic              BEN,
    output logic              BEN_valid,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       nzp_q, nzp_d;
    logic             ben_q, ben_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] taken_q, taken_d;

    logic [2:0]       new_nzp;
    logic [2:0]       cc_src;
    logic             ben_new;
    logic [CNT_W-1:0] br_base, taken_base;

    always_comb begin
        new_nzp[2] = Bus[DATA_W-1];
        new_nzp[1] = (Bus == '0);
        new_nzp[0] = ~Bus[DATA_W-1] & (Bus != '0);

        cc_src  = ((BYPASS != 0) && LD_CC) ? new_nzp : nzp_q;
        ben_new = |(IR_cond & cc_src);

        nzp_d = LD_CC  ? new_nzp : nzp_q;
        ben_d = LD_BEN ? ben_new : ben_q;

        // Without bypass, a BEN loaded alongside new flags used the old ones.
        valid_d = valid_q;
        if (LD_BEN)
            valid_d = ~LD_CC | (BYPASS != 0);
        else if (LD_CC)
            valid_d = 1'b0;

        // Clear happens first so a simultaneous evaluation is still counted.
        br_base    = Clr_Stats ? '0 : br_q;
        taken_base = Clr_Stats ? '0 : taken_q;
        br_d       = br_base;
        taken_d    = taken_base;
        if (LD_BEN) begin
            if (br_base != CNT_MAX)
                br_d = br_base + CNT_ONE;
            if (ben_new && (taken_base != CNT_MAX))
                taken_d = taken_base + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            nzp_q   <= 3'b010;
            ben_q   <= 1'b0;
            valid_q <= 1'b0;
            br_q    <= '0;
            taken_q <= '0;
        end else begin
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
            valid_q <= valid_d;
            br_q    <= br_d;
            taken_q <= taken_d;
        end
    end

    assign N           = nzp_q[2];
    assign Z           = nzp_q[1];
    assign P           = nzp_q[0];
    assign BEN         = ben_q;
    assign BEN_valid   = valid_q;
    assign br_count    = br_q;
    assign taken_count = taken_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench: three instances (default, bypass, 3-bit counters) share stimulus.
module tb_branch_cond_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_CC;
    logic [15:0] Bus;
    logic        LD_BEN;
    logic [2:0]  IR_cond;
    logic        Clr_Stats;

    logic        n0, z0, p0, ben0, vld0;
    logic [15:0] br0, tk0;
    logic        n1, z1, p1, ben1, vld1;
    logic [15:0] br1, tk1;
    logic        n2, z2, p2, ben2, vld2;
    logic [2:0]  br2, tk2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    branch_cond_unit #(.DATA_W(16), .CNT_W(16), .BYPASS(0)) u_d0 (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .Bus(Bus), .LD_BEN(LD_BEN),
        .IR_cond(IR_cond), .Clr_Stats(Clr_Stats), .N(n0), .Z(z0), .P(p0),
        .BEN(ben0), .BEN_valid(vld0), .br_count(br0), .taken_count(tk0));

    branch_cond_unit #(.DATA_W(16), .CNT_W(16), .BYPASS(1)) u_d1 (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .Bus(Bus), .LD_BEN(LD_BEN),
        .IR_cond(IR_cond), .Clr_Stats(Clr_Stats), .N(n1), .Z(z1), .P(p1),
        .BEN(ben1), .BEN_valid(vld1), .br_count(br1), .taken_count(tk1));

    branch_cond_unit #(.DATA_W(16), .CNT_W(3), .BYPASS(0)) u_d2 (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .Bus(Bus), .LD_BEN(LD_BEN),
        .IR_cond(IR_cond), .Clr_Stats(Clr_Stats), .N(n2), .Z(z2), .P(p2),
        .BEN(ben2), .BEN_valid(vld2), .br_count(br2), .taken_count(tk2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Apply the currently set inputs for one edge, then drop the one-shot strobes.
    task automatic step();
        @(posedge Clk);
        #1;
        LD_CC     = 1'b0;
        LD_BEN    = 1'b0;
        Clr_Stats = 1'b0;
        Reset     = 1'b1;
    endtask

    task automatic load_cc(input logic [15:0] v);
        LD_CC = 1'b1; Bus = v; step();
    endtask

    task automatic eval(input logic [2:0] c);
        LD_BEN = 1'b1; IR_cond = c; step();
    endtask

    logic [2:0] exp_nzp [4] = '{3'b100, 3'b010, 3'b001, 3'b001};
    logic [15:0] bus_v  [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
    logic [2:0] cond_v  [4] = '{3'b100, 3'b011, 3'b111, 3'b000};
    logic       ben_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // 1: reset beats simultaneous loads
        Reset = 1'b0; LD_CC = 1'b1; Bus = 16'h8000; LD_BEN = 1'b1;
        IR_cond = 3'b111; Clr_Stats = 1'b0;
        step();
        chk("rst_nzp", {n0, z0, p0}, 3'b010);
        chk("rst_ben", ben0, 1'b0);
        chk("rst_vld", vld0, 1'b0);
        chk("rst_br", br0, 0);
        chk("rst_tk", tk0, 0);
        chk("rst_br_c3", br2, 0);

        // 2: flag generation, one-hot
        for (int i = 0; i < 4; i++) begin
            load_cc(bus_v[i]);
            chk($sformatf("nzp_%0d", i), {n0, z0, p0}, exp_nzp[i]);
            chk($sformatf("onehot_%0d", i), $countones({n0, z0, p0}), 1);
        end

        // 3: OR-reduction against registered N
        load_cc(16'h8000);
        for (int i = 0; i < 4; i++) begin
            eval(cond_v[i]);
            chk($sformatf("ben_%0d", i), ben0, ben_v[i]);
            chk($sformatf("vld_%0d", i), vld0, 1'b1);
        end
        chk("br4", br0, 4);
        chk("tk2", tk0, 2);

        // 4: stale vs bypassed flags
        load_cc(16'h0000);
        LD_CC = 1'b1; Bus = 16'hFFFF; LD_BEN = 1'b1; IR_cond = 3'b100;
        step();
        chk("nobyp_ben", ben0, 1'b0);
        chk("nobyp_vld", vld0, 1'b0);
        chk("nobyp_n", n0, 1'b1);
        chk("byp_ben", ben1, 1'b1);
        chk("byp_vld", vld1, 1'b1);
        chk("byp_tk", tk1, 3);
        chk("nobyp_tk", tk0, 2);

        // 5: saturation on the 3-bit counters, then clear-and-count
        Clr_Stats = 1'b1; step();
        chk("clr_br", br2, 0);
        chk("clr_tk", tk2, 0);
        for (int i = 0; i < 9; i++) eval(3'b111);
        chk("sat_br", br2, 7);
        chk("sat_tk", tk2, 7);
        chk("nosat_br", br0, 9);
        Clr_Stats = 1'b1; eval(3'b000);
        chk("clrcnt_br", br2, 1);
        chk("clrcnt_tk", tk2, 0);

        // 6: LD_CC alone invalidates without touching BEN
        eval(3'b100);
        chk("pre_ben", ben0, 1'b1);
        chk("pre_vld", vld0, 1'b1);
        load_cc(16'h0005);
        chk("inv_vld", vld0, 1'b0);
        chk("inv_ben", ben0, 1'b1);
        chk("inv_nzp", {n0, z0, p0}, 3'b001);
        eval(3'b100);
        chk("p_ben0", ben0, 1'b0);
        eval(3'b001);
        chk("p_ben1", ben0, 1'b1);
        chk("p_vld", vld0, 1'b1);

        // reset discards a simultaneous count
        Reset = 1'b0; LD_BEN = 1'b1; IR_cond = 3'b111;
        step();
        chk("rst2_br", br0, 0);
        chk("rst2_tk", tk0, 0);
        chk("rst2_ben", ben0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
